// File: rtl/key_event_queue_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : key_event_queue_pkg
//  Description : Shared defaults and width helper for the key event queue.
//  Revision    : 1.0 - initial release
// ============================================================================
package key_event_queue_pkg;

    localparam int KEY_N_DEFAULT      = 4;
    localparam int EVTQ_DEPTH_DEFAULT = 8;

    // Bits needed to encode values 0..n-1, never less than one bit.
    function automatic int width_for(input int n);
        int w;
        w = $clog2(n);
        return (w < 1) ? 1 : w;
    endfunction

endpackage : key_event_queue_pkg
`default_nettype wire

// File: rtl/key_event_queue_sync_fifo_fwft.sv
`default_nettype none
// ============================================================================
//  Module      : sync_fifo_fwft
//  Description : Single-clock first-word-fall-through FIFO. The head entry is
//                visible on rd_data whenever the FIFO is not empty; rd_data
//                reads as zero while empty.
//  Revision    : 1.0 - initial release
// ============================================================================
module sync_fifo_fwft
    import key_event_queue_pkg::*;
#(
    parameter  int WIDTH = 2,
    parameter  int DEPTH = EVTQ_DEPTH_DEFAULT,
    localparam int CNT_W = width_for(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             wr_en,
    input  logic [WIDTH-1:0] wr_data,
    input  logic             rd_en,
    output logic [WIDTH-1:0] rd_data,
    output logic [CNT_W-1:0] count,
    output logic             full,
    output logic             empty
);

    localparam int AW = width_for(DEPTH);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW-1:0]    r_wr_ptr;
    logic [AW-1:0]    r_rd_ptr;
    logic [CNT_W-1:0] r_count;
    logic             w_do_rd;
    logic             w_do_wr;

    assign empty   = (r_count == '0);
    assign full    = (r_count == CNT_W'(DEPTH));
    assign count   = r_count;
    assign rd_data = empty ? '0 : r_mem[r_rd_ptr];

    // A read on an empty FIFO is ignored; a write when full is allowed only
    // if a read frees the slot in the same cycle.
    assign w_do_rd = rd_en & ~empty;
    assign w_do_wr = wr_en & (~full | w_do_rd);

    // Storage array: no reset needed, entries are only read once written.
    always_ff @(posedge clk) begin
        if (w_do_wr) begin
            r_mem[r_wr_ptr] <= wr_data;
        end
    end

    // Pointers and occupancy; pointers wrap naturally since DEPTH is 2^AW.
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_do_wr) begin
                r_wr_ptr <= r_wr_ptr + AW'(1);
            end
            if (w_do_rd) begin
                r_rd_ptr <= r_rd_ptr + AW'(1);
            end
            r_count <= r_count + CNT_W'(w_do_wr) - CNT_W'(w_do_rd);
        end
    end

endmodule : sync_fifo_fwft
`default_nettype wire

// File: rtl/key_event_queue.sv
`default_nettype none
// ============================================================================
//  Module      : key_event_queue
//  Description : Serialises one-cycle key pulses into key-index events,
//                buffered in a FWFT FIFO behind a valid/ready handshake.
//                Simultaneous presses leave in ascending key order; a press
//                on a key whose previous event is still pending is lost and
//                raises a sticky overflow flag.
//  Revision    : 1.0 - initial release
// ============================================================================
module key_event_queue
    import key_event_queue_pkg::*;
#(
    parameter  int N     = KEY_N_DEFAULT,
    parameter  int DEPTH = EVTQ_DEPTH_DEFAULT,
    localparam int IDX_W = width_for(N),
    localparam int CNT_W = width_for(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [N-1:0]     key_pulse,
    output logic             evt_valid,
    output logic [IDX_W-1:0] evt_code,
    input  logic             evt_ready,
    output logic [CNT_W-1:0] count,
    output logic             overflow,
    input  logic             ovf_clr
);

    logic [N-1:0]     r_pend;
    logic             r_overflow;
    logic [N-1:0]     w_grant;
    logic [IDX_W-1:0] w_grant_idx;
    logic             w_found;
    logic             w_full;
    logic             w_empty;
    logic             w_pop;
    logic             w_push_ok;
    logic             w_loss;

    assign evt_valid = ~w_empty;
    assign overflow  = r_overflow;
    assign w_pop     = evt_valid & evt_ready;
    assign w_push_ok = ~w_full | w_pop;

    // Lowest-index pending key wins the single push slot of this cycle.
    always_comb begin
        w_grant     = '0;
        w_grant_idx = '0;
        w_found     = 1'b0;
        for (int i = 0; i < N; i++) begin
            if (w_push_ok && r_pend[i] && !w_found) begin
                w_grant[i]  = 1'b1;
                w_grant_idx = IDX_W'(i);
                w_found     = 1'b1;
            end
        end
    end

    // A new pulse on a key that is pending and not leaving this cycle is lost.
    assign w_loss = |(key_pulse & r_pend & ~w_grant);

    // Pending presses: granted bits leave, new pulses (re)arm their bits.
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_pend <= '0;
        end else begin
            r_pend <= (r_pend & ~w_grant) | key_pulse;
        end
    end

    // Sticky loss flag; a new loss takes priority over a clear request.
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_overflow <= 1'b0;
        end else if (w_loss) begin
            r_overflow <= 1'b1;
        end else if (ovf_clr) begin
            r_overflow <= 1'b0;
        end
    end

    sync_fifo_fwft #(
        .WIDTH (IDX_W),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .wr_en   (w_found),
        .wr_data (w_grant_idx),
        .rd_en   (evt_ready),
        .rd_data (evt_code),
        .count   (count),
        .full    (w_full),
        .empty   (w_empty)
    );

endmodule : key_event_queue
`default_nettype wire
